// File: rtl/sirius_mem_pkg.sv
// Shared types and constants for the memory-side refill path.
package sirius_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  typedef logic req_id_t;

  localparam int unsigned REFILL_BURST_LEN = 16;
  localparam logic [7:0]  AR_LEN           = 8'(REFILL_BURST_LEN - 1);

  // AXI length field is beats minus one.
  function automatic logic [7:0] ar_len_of(input int unsigned beats);
    return 8'(beats - 1);
  endfunction

endpackage

// File: rtl/cache_refill_arbiter_grant.sv
// Two-way winner select for refill requests.
// ARB_ROUND_ROBIN_EN selects round-robin ties; otherwise req 1 wins ties.
module arb2_grant
  import sirius_mem_pkg::*;
(
  input  logic [1:0] req_valid,
`ifdef ARB_ROUND_ROBIN_EN
  input  req_id_t    rr_ptr,
`endif
  output req_id_t    win
);

  always_comb begin
    win = 1'b0;
    case (req_valid)
      2'b01: win = 1'b0;
      2'b10: win = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
      2'b11: win = rr_ptr;
`else
      2'b11: win = 1'b1;
`endif
      default: win = 1'b0;
    endcase
  end

endmodule

// File: rtl/cache_refill_arbiter.sv
// Shares one AXI-style AR/R burst read port between icache (0) and dcache (1).
// ARB_ROUND_ROBIN_EN: round-robin tie break; default is fixed priority to dcache.
module cache_refill_arbiter
  import sirius_mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_LEN = REFILL_BURST_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ok,
  output logic [DATA_W-1:0]   rd_data,
  output logic [1:0]          rd_valid,
  output logic [1:0]          rd_last,
  output logic [ADDR_W-1:0]   mem_araddr,
  output logic [7:0]          mem_arlen,
  output logic                mem_arvalid,
  input  logic                mem_arready,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_rvalid,
  input  logic                mem_rlast,
  output logic                mem_rready,
  output logic                err_len
);

  localparam int unsigned     CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

  arb_state_t        state;
  req_id_t           grant;
  req_id_t           win;
  logic [CNT_W-1:0]  beat_cnt;
  logic [ADDR_W-1:0] araddr_q;
  logic [ADDR_W-1:0] win_addr;
  logic              arvalid_q;
  logic              rready_q;
  logic              err_q;
`ifdef ARB_ROUND_ROBIN_EN
  req_id_t           rr_ptr;
`endif

  arb2_grant u_grant (
    .req_valid (req_valid),
`ifdef ARB_ROUND_ROBIN_EN
    .rr_ptr    (rr_ptr),
`endif
    .win       (win)
  );

  assign win_addr = win ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      beat_cnt  <= '0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      err_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant     <= win;
            araddr_q  <= win_addr;
            arvalid_q <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (arvalid_q && mem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            if (beat_cnt != LAST_CNT)
              beat_cnt <= beat_cnt + 1'b1;
            // Early rlast, or a full count of beats with no rlast, is a length error.
            if (mem_rlast ? (beat_cnt != LAST_CNT) : (beat_cnt == LAST_CNT))
              err_q <= 1'b1;
            if (mem_rlast) begin
              rready_q <= 1'b0;
              state    <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
              rr_ptr   <= ~grant;
`endif
            end
          end
        end
        default: begin
          state     <= IDLE;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
        end
      endcase
    end
  end

  // Handshake pulses are steered to the granted requester and muted under reset.
  always_comb begin
    req_ok   = '0;
    rd_valid = '0;
    rd_last  = '0;
    if (!rst) begin
      if (arvalid_q && mem_arready)
        req_ok[grant] = 1'b1;
      if (rready_q && mem_rvalid) begin
        rd_valid[grant] = 1'b1;
        rd_last[grant]  = mem_rlast;
      end
    end
  end

  assign rd_data     = mem_rdata;
  assign mem_araddr  = araddr_q;
  assign mem_arlen   = ar_len_of(BURST_LEN);
  assign mem_arvalid = arvalid_q;
  assign mem_rready  = rready_q;
  assign err_len     = err_q;

endmodule

// File: tb/tb_cache_refill_arbiter.sv
// Randomized self-checking bench for cache_refill_arbiter against a burst-level model.
module tb_cache_refill_arbiter;
  import sirius_mem_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BL     = 16;
`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          req_valid, req_ok, rd_valid, rd_last;
  logic [DATA_W-1:0]   rd_data, mem_rdata;
  logic [ADDR_W-1:0]   mem_araddr;
  logic [7:0]          mem_arlen;
  logic                mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready, err_len;

  always #5 clk = ~clk;

  cache_refill_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .req_addr(req_addr), .req_valid(req_valid), .req_ok(req_ok),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .mem_rlast(mem_rlast), .mem_rready(mem_rready), .err_len(err_len)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Reference model: who should be served next and whether a length error has been seen.
  bit pref;
  bit err_model;

  function automatic logic model_winner(input logic [1:0] v);
    case (v)
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      2'b11:   return RR_MODE ? pref : 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit queues_equal(input logic [DATA_W-1:0] a[$], input logic [DATA_W-1:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Observations of the most recent burst and the model's expectations for it.
  logic              obs_w, exp_w, obs_err_idle, exp_err_idle;
  logic [ADDR_W-1:0] obs_addr, exp_addr;
  logic [7:0]        obs_arlen;
  bit                obs_idle_ok, obs_ar_lat, obs_rst_quiet;
  int unsigned       obs_ar_bad, obs_ar_cycles, obs_ok_pulses, obs_spur, obs_last_cnt, obs_last_idx;
  logic [DATA_W-1:0] obs_data[$], exp_data[$];

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    @(negedge clk);
    pref = 1'b0; err_model = 1'b0;
  endtask

  // Runs one burst from IDLE as both requesters and memory; records what the DUT did.
  task automatic do_burst(input logic [1:0] v, input logic [1:0] v_extra,
                          input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                          input int unsigned ar_wait, input bit gaps,
                          input int unsigned nbeats, input int unsigned rst_beat);
    logic [DATA_W-1:0] d;
    logic [1:0]        v_hold;
    exp_w = model_winner(v); exp_addr = exp_w ? a1 : a0; exp_err_idle = err_model;
    obs_ar_bad = 0; obs_ar_cycles = 0; obs_ok_pulses = 0; obs_spur = 0;
    obs_last_cnt = 0; obs_last_idx = 0; obs_rst_quiet = 1'b0; obs_w = 1'bx;
    obs_data.delete(); exp_data.delete();
    @(negedge clk);
    rst = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; mem_arready = 1'b0;
    req_addr = {a1, a0}; req_valid = v;
    #1;
    obs_idle_ok  = (mem_arvalid === 1'b0) && (mem_rready === 1'b0) &&
                   (rd_valid === 2'b00) && (req_ok === 2'b00);
    obs_err_idle = err_len;
    v_hold = v | v_extra;
    for (int unsigned c = 0; c <= ar_wait; c++) begin
      @(negedge clk);
      mem_arready = (c == ar_wait);
      #1;
      if (c == 0) begin
        obs_ar_lat = (mem_arvalid === 1'b1); obs_addr = mem_araddr; obs_arlen = mem_arlen;
      end
      if (mem_arvalid !== 1'b1 || mem_araddr !== obs_addr) obs_ar_bad++;
      if (mem_arvalid === 1'b1) obs_ar_cycles++;
      obs_ok_pulses += $countones(req_ok);
      if (c == ar_wait) begin
        obs_w  = req_ok[1];
        v_hold = (v & ~req_ok) | v_extra;
      end
    end
    for (int unsigned k = 1; k <= nbeats; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        @(negedge clk);
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; req_valid = v_hold;
        #1;
        if (rd_valid !== 2'b00 || rd_last !== 2'b00 || req_ok !== 2'b00 ||
            mem_arvalid !== 1'b0 || mem_rready !== 1'b1) obs_spur++;
      end
      @(negedge clk);
      mem_arready = 1'b0; req_valid = v_hold;
      d = $urandom; mem_rdata = d; mem_rvalid = 1'b1;
      if (k == rst_beat) begin
        rst = 1'b1; mem_rlast = 1'b0;
        #1;
        obs_rst_quiet = (rd_valid === 2'b00) && (rd_last === 2'b00) && (req_ok === 2'b00);
        pref = 1'b0; err_model = 1'b0;
        return;
      end
      mem_rlast = (k == nbeats);
      exp_data.push_back(d);
      #1;
      if (rd_valid[obs_w] === 1'b1) obs_data.push_back(rd_data);
      if (rd_valid[~obs_w] !== 1'b0 || rd_last[~obs_w] !== 1'b0 || req_ok !== 2'b00 ||
          mem_arvalid !== 1'b0 || mem_rready !== 1'b1) obs_spur++;
      if (rd_last[obs_w] === 1'b1) begin obs_last_cnt++; obs_last_idx = k; end
    end
    pref = ~exp_w;
    if (nbeats != BL) err_model = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    mem_rdata = $urandom;
    #1;
    n_cmp++; if (mem_arvalid !== 1'b0 || mem_rready !== 1'b0) begin n_bad++;
      $display("FAIL reset_mem: arvalid=%b rready=%b, required 0 0", mem_arvalid, mem_rready); end
    n_cmp++; if (req_ok !== 2'b00 || rd_valid !== 2'b00 || rd_last !== 2'b00) begin n_bad++;
      $display("FAIL reset_req: req_ok=%b rd_valid=%b rd_last=%b, required 00", req_ok, rd_valid, rd_last); end
    n_cmp++; if (err_len !== 1'b0 || mem_araddr !== '0) begin n_bad++;
      $display("FAIL reset_regs: err_len=%b araddr=%h, required 0 0", err_len, mem_araddr); end
    n_cmp++; if (mem_arlen !== 8'd15 || rd_data !== mem_rdata) begin n_bad++;
      $display("FAIL reset_const: arlen=%0d rd_data=%h, required 15 %h", mem_arlen, rd_data, mem_rdata); end
  endtask

  task automatic test_single();
    do_burst(2'b01, 2'b00, 32'h0000_1040, 32'h0000_2000, 0, 1'b0, BL, 0);
    n_cmp++; if (!obs_idle_ok || !obs_ar_lat) begin n_bad++;
      $display("FAIL single_latency: idle_ok=%b arvalid_next=%b, required 1 1", obs_idle_ok, obs_ar_lat); end
    n_cmp++; if (obs_addr !== 32'h0000_1040 || obs_arlen !== 8'd15) begin n_bad++;
      $display("FAIL single_ar: araddr=%h arlen=%0d, required 00001040 15", obs_addr, obs_arlen); end
    n_cmp++; if (obs_w !== 1'b0 || obs_ok_pulses != 1) begin n_bad++;
      $display("FAIL single_ok: winner=%b pulses=%0d, required 0 1", obs_w, obs_ok_pulses); end
    n_cmp++; if (!queues_equal(obs_data, exp_data)) begin n_bad++;
      $display("FAIL single_data: got %0d beats, required %0d matching", obs_data.size(), exp_data.size()); end
    n_cmp++; if (obs_last_cnt != 1 || obs_last_idx != 16 || obs_spur != 0) begin n_bad++;
      $display("FAIL single_last: last_cnt=%0d last_beat=%0d stray=%0d, required 1 16 0",
               obs_last_cnt, obs_last_idx, obs_spur); end
  endtask

  task automatic test_tie();
    logic [ADDR_W-1:0] a0, a1;
    logic              first_w;
    apply_reset();
    a0 = $urandom & 32'hFFFF_FFC0; a1 = $urandom & 32'hFFFF_FFC0;
    do_burst(2'b11, 2'b00, a0, a1, 0, 1'b0, BL, 0);
    first_w = exp_w;
    n_cmp++; if (obs_w !== exp_w || obs_addr !== exp_addr) begin n_bad++;
      $display("FAIL tie_first: winner=%b addr=%h, required %b %h", obs_w, obs_addr, exp_w, exp_addr); end
    do_burst(first_w ? 2'b01 : 2'b10, 2'b00, a0, a1, $urandom_range(0, 2), 1'b0, BL, 0);
    n_cmp++; if (!obs_idle_ok || obs_w !== exp_w || obs_addr !== exp_addr) begin n_bad++;
      $display("FAIL tie_loser: idle_ok=%b winner=%b addr=%h, required 1 %b %h",
               obs_idle_ok, obs_w, obs_addr, exp_w, exp_addr); end
    do_burst(2'b11, 2'b00, a0, a1, 0, 1'b0, BL, 0);
    n_cmp++; if (obs_w !== exp_w || !queues_equal(obs_data, exp_data)) begin n_bad++;
      $display("FAIL tie_second: winner=%b beats=%0d, required %b %0d",
               obs_w, obs_data.size(), exp_w, exp_data.size()); end
  endtask

  task automatic test_ar_stall();
    do_burst(2'b10, 2'b00, $urandom & 32'hFFFF_FFC0, $urandom & 32'hFFFF_FFC0, 5, 1'b0, BL, 0);
    n_cmp++; if (obs_ar_cycles != 6 || obs_ar_bad != 0) begin n_bad++;
      $display("FAIL stall_ar: arvalid_cycles=%0d unstable=%0d, required 6 0", obs_ar_cycles, obs_ar_bad); end
    n_cmp++; if (obs_ok_pulses != 1 || obs_w !== 1'b1 || obs_addr !== exp_addr) begin n_bad++;
      $display("FAIL stall_ok: pulses=%0d winner=%b addr=%h, required 1 1 %h",
               obs_ok_pulses, obs_w, obs_addr, exp_addr); end
  endtask

  task automatic test_gaps();
    do_burst(2'b01, 2'b00, $urandom & 32'hFFFF_FFC0, 32'h0, 1, 1'b1, BL, 0);
    n_cmp++; if (!queues_equal(obs_data, exp_data) || obs_spur != 0) begin n_bad++;
      $display("FAIL gaps_data: got %0d beats stray=%0d, required %0d 0",
               obs_data.size(), obs_spur, exp_data.size()); end
    do_burst(2'b10, 2'b00, 32'h0, $urandom & 32'hFFFF_FFC0, 0, 1'b1, BL, 0);
    n_cmp++; if (obs_err_idle !== 1'b0) begin n_bad++;
      $display("FAIL gaps_err: err_len=%b, required 0", obs_err_idle); end
  endtask

  task automatic test_short();
    do_burst(2'b01, 2'b00, $urandom & 32'hFFFF_FFC0, 32'h0, 0, 1'b0, 12, 0);
    n_cmp++; if (obs_last_idx != 12 || obs_data.size() != 12 || obs_err_idle !== 1'b0) begin n_bad++;
      $display("FAIL short_end: last_beat=%0d beats=%0d err_before=%b, required 12 12 0",
               obs_last_idx, obs_data.size(), obs_err_idle); end
    do_burst(2'b10, 2'b00, 32'h0, $urandom & 32'hFFFF_FFC0, 0, 1'b1, BL, 0);
    n_cmp++; if (obs_err_idle !== 1'b1 || !obs_idle_ok) begin n_bad++;
      $display("FAIL short_err: err_len=%b idle_ok=%b, required 1 1", obs_err_idle, obs_idle_ok); end
    n_cmp++; if (!queues_equal(obs_data, exp_data) || obs_last_idx != 16) begin n_bad++;
      $display("FAIL short_next: beats=%0d last_beat=%0d, required %0d 16",
               obs_data.size(), obs_last_idx, exp_data.size()); end
  endtask

  task automatic test_reset_mid();
    logic [ADDR_W-1:0] a1;
    a1 = $urandom & 32'hFFFF_FFC0;
    do_burst(2'b01, 2'b10, $urandom & 32'hFFFF_FFC0, a1, 0, 1'b0, BL, 7);
    n_cmp++; if (!obs_rst_quiet || obs_data.size() != 6) begin n_bad++;
      $display("FAIL rstmid_quiet: quiet=%b beats=%0d, required 1 6", obs_rst_quiet, obs_data.size()); end
    do_burst(2'b10, 2'b00, 32'h0, a1, 0, 1'b0, BL, 0);
    n_cmp++; if (!obs_idle_ok || obs_err_idle !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_idle: idle_ok=%b err_len=%b, required 1 0", obs_idle_ok, obs_err_idle); end
    n_cmp++; if (obs_w !== 1'b1 || obs_addr !== a1 || !queues_equal(obs_data, exp_data)) begin n_bad++;
      $display("FAIL rstmid_regrant: winner=%b addr=%h beats=%0d, required 1 %h %0d",
               obs_w, obs_addr, obs_data.size(), a1, exp_data.size()); end
  endtask

  task automatic test_random();
    logic [1:0]        pend, newreq, v;
    logic [ADDR_W-1:0] a0, a1;
    int unsigned       nb;
    pend = 2'b00; a0 = '0; a1 = '0;
    for (int unsigned it = 0; it < 24; it++) begin
      newreq = 2'($urandom_range(0, 3));
      v = pend | newreq;
      if (v == 2'b00) begin v = 2'($urandom_range(1, 3)); newreq = v; end
      if (newreq[0] && !pend[0]) a0 = $urandom & 32'hFFFF_FFC0;
      if (newreq[1] && !pend[1]) a1 = $urandom & 32'hFFFF_FFC0;
      nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, BL) : BL;
      do_burst(v, 2'b00, a0, a1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), nb, 0);
      n_cmp++; if (obs_w !== exp_w || obs_addr !== exp_addr || obs_ok_pulses != 1) begin n_bad++;
        $display("FAIL rand_grant[%0d]: v=%b winner=%b addr=%h pulses=%0d, required %b %h 1",
                 it, v, obs_w, obs_addr, obs_ok_pulses, exp_w, exp_addr); end
      n_cmp++; if (!queues_equal(obs_data, exp_data) || obs_last_idx != nb || obs_spur != 0) begin n_bad++;
        $display("FAIL rand_data[%0d]: beats=%0d last_beat=%0d stray=%0d, required %0d %0d 0",
                 it, obs_data.size(), obs_last_idx, obs_spur, exp_data.size(), nb); end
      n_cmp++; if (!obs_idle_ok || obs_err_idle !== exp_err_idle) begin n_bad++;
        $display("FAIL rand_idle[%0d]: idle_ok=%b err_len=%b, required 1 %b",
                 it, obs_idle_ok, obs_err_idle, exp_err_idle); end
      pend = v & ~(exp_w ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; mem_rlast = 1'b0; req_valid = pend;
    #1;
    n_cmp++; if (err_len !== err_model || mem_arvalid !== 1'b0) begin n_bad++;
      $display("FAIL rand_final: err_len=%b arvalid=%b, required %b 0", err_len, mem_arvalid, err_model); end
  endtask

  initial begin
    rst = 1'b1; req_addr = '0; req_valid = '0; mem_arready = 1'b0;
    mem_rdata = '0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    pref = 1'b0; err_model = 1'b0;
    test_reset();
    test_single();
    test_tie();
    test_ar_stall();
    test_gaps();
    test_short();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
